uart_tx_frame_engine: RTL and testbench

UART transmitter that serializes a parallel word into a standard asynchronous frame: start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, and one stop bit. It is the transmit-side counterpart of the UART receiver control path in the APB-UART bridge. Bit timing comes from an internal per-bit clock counter driven by the run-time prescale value. The parallel side uses a valid/ready handshake to the bridge TX buffer.

---
 rtl/uart_tx_frame_engine_if.sv | 21 ++
 rtl/uart_tx_frame_engine.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_engine_if.sv
// Parallel-side handshake between the bridge TX buffer (master) and the
// UART transmit frame engine (slave).
//
// Signals:
//   tx_data  - word to transmit, driven by the master
//   tx_valid - master has a word on tx_data
//   tx_ready - slave can accept a word this cycle
//
// Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready
// are both high. While tx_valid is high and tx_ready is low, the master holds
// tx_data unchanged. tx_ready does not depend on tx_valid.
interface uart_tx_frame_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame_engine.sv
// UART transmitter. It serializes one parallel word per frame: a start bit,
// DATA_WIDTH data bits LSB first, an optional parity bit and one stop bit.
// Each bit lasts P clk cycles. P is the prescale value latched at accept,
// with a minimum of 4.
//
// Ports:
//   clk, reset      - system clock; asynchronous, active-low reset
//   parity_en       - insert a parity bit after the data bits
//   parity_type     - 0 = even parity, 1 = odd parity
//   prescale        - clk cycles per bit (values below 4 act as 4)
//   tx_if           - tx_data/tx_valid/tx_ready handshake (slave side)
//   serial_data_out - UART TX line, idle high
//   busy            - frame in progress
//   frame_done      - one-cycle pulse when the stop bit period ends
//   dbg_state       - current FSM state encoding
module uart_tx_frame_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 parity_en,
    input  logic                 parity_type,
    input  logic [5:0]           prescale,
    uart_tx_frame_engine_if.slave tx_if,
    output logic                 serial_data_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic [2:0]           dbg_state
);
    localparam int BIDX_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [5:0]            period_q, period_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  line_q, line_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    assign bit_end = (edge_cnt_q == period_q - 6'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            period_q   <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            line_q     <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            period_q   <= period_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            line_q     <= line_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q + 6'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        period_d   = period_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                if (tx_if.tx_valid && ready_q) begin
                    shift_d   = tx_if.tx_data;
                    par_en_d  = parity_en;
                    par_bit_d = (^tx_if.tx_data) ^ parity_type;
                    period_d  = (prescale < 6'd4) ? 6'd4 : prescale;
                    bit_idx_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    bit_idx_d  = bit_idx_q + 1'b1;
                    if (bit_idx_q == BIDX_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                edge_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        // The line is registered from the current state. It therefore trails
        // the state by one cycle, and the start bit begins one edge after the
        // accept edge.
        case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
            S_PARITY: line_d = par_bit_q;
            default:  line_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    assign tx_if.tx_ready  = ready_q;
    assign serial_data_out = line_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
module tb_uart_tx_frame_engine;
    localparam int DW = 8;

    logic       clk;
    logic       reset;
    logic       parity_en;
    logic       parity_type;
    logic [5:0] prescale;
    logic       serial_data_out;
    logic       busy;
    logic       frame_done;
    logic [2:0] dbg_state;

    int total_cnt = 0;
    int bad_cnt   = 0;

    uart_tx_frame_engine_if #(.DATA_WIDTH(DW)) tx_if ();

    uart_tx_frame_engine #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .prescale        (prescale),
        .tx_if           (tx_if),
        .serial_data_out (serial_data_out),
        .busy            (busy),
        .frame_done      (frame_done),
        .dbg_state       (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Waits for the accept edge with tx_valid already high. On return the
    // time is 1 ns after that edge.
    task automatic wait_accept(output logic ok);
        logic rdy_before;
        int   waited;
        waited = 0;
        do begin
            rdy_before = tx_if.tx_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy_before && waited < 2000);
        ok = rdy_before;
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: the frame as a list of line levels, one entry per bit.
    task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                               output logic exp_q[$], output logic par);
        int ones;
        ones = 0;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(((d >> i) & 1) == 1);
            ones += (d >> i) & 1;
        end
        par = (pt == 1'b0) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        if (pe) exp_q.push_back(par);
        exp_q.push_back(1'b1);
    endtask

    // Sends one word and checks the frame cycle by cycle. Two cycles after the
    // accept edge, the inputs are changed to the "after" values. With hold set,
    // tx_valid stays high, so those values form the next queued word.
    task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input logic hold,
                             input logic [DW-1:0] a_d, input logic a_pe,
                             input logic a_pt, input logic [5:0] a_ps);
        logic exp_q[$];
        logic got_q[$];
        logic par;
        logic ok;
        logic [DW-1:0] dec;
        int p, f, idx;
        p = (ps < 4) ? 4 : int'(ps);
        build_frame(d, pe, pt, exp_q, par);
        f = exp_q.size() * p;

        tx_if.tx_data   = d;
        parity_en       = pe;
        parity_type     = pt;
        prescale        = ps;
        tx_if.tx_valid  = 1'b1;
        wait_accept(ok);
        if (!ok) begin
            tx_if.tx_valid = 1'b0;
            return;
        end
        check_eq("gap_line", serial_data_out, 1'b1);
        check_eq("done_one_cycle", frame_done, 1'b0);
        check_eq("accept_ready_low", tx_if.tx_ready, 1'b0);
        if (!hold) tx_if.tx_valid = 1'b0;

        for (int c = 1; c <= f; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                tx_if.tx_data = a_d;
                parity_en     = a_pe;
                parity_type   = a_pt;
                prescale      = a_ps;
            end
            idx = (c - 1) / p;
            check_eq("line", serial_data_out, exp_q[idx]);
            if ((c - 1) % p == p / 2) got_q.push_back(serial_data_out);
            check_eq("frame_done", frame_done, c == f);
            check_eq("tx_ready", tx_if.tx_ready, c == f);
            check_eq("busy", busy, c != f);
        end

        // Decode the frame from the mid-bit samples.
        check_eq("dec_len", got_q.size(), exp_q.size());
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < DW; i++) dec[i] = got_q[1 + i];
            check_eq("dec_start", got_q[0], 1'b0);
            check_eq("dec_data", dec, d);
            if (pe) check_eq("dec_parity", got_q[DW + 1], par);
            check_eq("dec_stop", got_q[got_q.size() - 1], 1'b1);
        end
    endtask

    initial begin
        logic ok;
        logic [DW-1:0] rd;
        reset          = 1'b0;
        parity_en      = 1'b0;
        parity_type    = 1'b0;
        prescale       = 6'd8;
        tx_if.tx_data  = '0;
        tx_if.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_line", serial_data_out, 1'b1);
        check_eq("rst_ready", tx_if.tx_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        check_eq("rst_state", dbg_state, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame. Prescale and parity are changed mid-frame, and the
        // next frame must use the new settings.
        run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 8'h00, 1'b1, 1'b1, 6'd16);
        run_frame(8'h3C, 1'b1, 1'b0, 6'd16, 1'b0, 8'hFF, 1'b0, 1'b0, 6'd5);
        run_frame(8'h3C, 1'b1, 1'b1, 6'd16, 1'b0, 8'h12, 1'b0, 1'b0, 6'd63);
        run_frame(8'h07, 1'b1, 1'b0, 6'd6, 1'b0, 8'h00, 1'b0, 1'b1, 6'd4);
        run_frame(8'h07, 1'b1, 1'b1, 6'd6, 1'b0, 8'h00, 1'b0, 1'b0, 6'd4);

        // Back-to-back: tx_valid stays high across both words.
        run_frame(8'h55, 1'b0, 1'b0, 6'd4, 1'b1, 8'hAA, 1'b0, 1'b0, 6'd4);
        run_frame(8'hAA, 1'b0, 1'b0, 6'd4, 1'b0, 8'h00, 1'b0, 1'b0, 6'd4);

        // Reset pulse during data bit 3
        tx_if.tx_data  = 8'hC3;
        parity_en      = 1'b0;
        prescale       = 6'd8;
        tx_if.tx_valid = 1'b1;
        wait_accept(ok);
        tx_if.tx_valid = 1'b0;
        if (ok) begin
            repeat (36) @(posedge clk);
            #1;
            reset = 1'b0;
            #1;
            check_eq("mid_rst_line", serial_data_out, 1'b1);
            check_eq("mid_rst_busy", busy, 1'b0);
            check_eq("mid_rst_ready", tx_if.tx_ready, 1'b1);
            check_eq("mid_rst_done", frame_done, 1'b0);
            check_eq("mid_rst_state", dbg_state, 3'd0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                check_eq("post_rst_done", frame_done, 1'b0);
                check_eq("post_rst_line", serial_data_out, 1'b1);
            end
        end
        // A prescale below the minimum acts as 4, which gives a 40-cycle frame.
        run_frame(8'h81, 1'b0, 1'b0, 6'd2, 1'b0, 8'h00, 1'b0, 1'b0, 6'd2);

        // Random frames
        for (int n = 0; n < 16; n++) begin
            rd = DW'($urandom_range(0, 255));
            run_frame(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 20)), 1'b0,
                      DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
